// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited requests to an
// in-order, variable-latency instruction memory and buffers words for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Stale requests pile up across back-to-back redirects, so the
  // outstanding/drop counters get headroom beyond the buffer depth.
  localparam int OUT_W = PTR_W + 6;

  logic [31:0]      r_req_pc;
  logic [31:0]      r_fifo_pc   [BUF_DEPTH];
  logic [31:0]      r_fifo_word [BUF_DEPTH];
  logic [PTR_W-1:0] r_fifo_wr;
  logic [PTR_W-1:0] r_fifo_rd;
  logic [CNT_W-1:0] r_fifo_cnt;
  logic [31:0]      r_pcq [BUF_DEPTH];
  logic [PTR_W-1:0] r_pcq_wr;
  logic [PTR_W-1:0] r_pcq_rd;
  logic [OUT_W-1:0] r_outstanding;
  logic [OUT_W-1:0] r_drop_cnt;
  logic             r_halted;

  logic [OUT_W-1:0] w_live;
  logic [OUT_W-1:0] w_occupancy;
  logic             w_grant;
  logic             w_flush;
  logic             w_keep;
  logic             w_drop;
  logic             w_push;
  logic             w_pop;
  logic             w_fifo_nonempty;
  logic [31:0]      w_pcq_head;
  logic [OUT_W-1:0] w_out_next;
  logic [OUT_W-1:0] w_drop_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [31:0]      w_req_pc_next;

  // Credit counts buffered words plus live (non-stale) in-flight requests.
  assign w_live      = r_outstanding - r_drop_cnt;
  assign w_occupancy = OUT_W'(r_fifo_cnt) + w_live;

  assign imem_req  = !rst && !r_halted && !redirect &&
                     (w_occupancy < OUT_W'(BUF_DEPTH));
  assign imem_addr = r_req_pc;

  assign w_grant = imem_req && imem_gnt;
  assign w_flush = halt || redirect;
  assign w_drop  = imem_rvalid && (r_drop_cnt != '0);
  assign w_keep  = imem_rvalid && (r_drop_cnt == '0);
  assign w_push  = w_keep && !w_flush;

  assign w_fifo_nonempty = (r_fifo_cnt != '0);
  assign inst_valid      = w_fifo_nonempty && !r_halted;
  assign w_pop           = inst_valid && inst_ready;
  assign inst            = w_fifo_nonempty ? r_fifo_word[r_fifo_rd] : '0;
  assign inst_pc         = w_fifo_nonempty ? r_fifo_pc[r_fifo_rd]   : '0;
  assign halted          = r_halted;

  // pc_q only tracks live requests; a flush discards its contents, so the
  // PC popped on a kept response always belongs to that response.
  assign w_pcq_head = r_pcq[r_pcq_rd];

  always_comb begin
    w_out_next = r_outstanding;
    if (w_grant && !imem_rvalid) begin
      w_out_next = r_outstanding + OUT_W'(1);
    end else if (!w_grant && imem_rvalid) begin
      w_out_next = r_outstanding - OUT_W'(1);
    end
  end

  always_comb begin
    w_drop_next = r_drop_cnt;
    if (w_flush) begin
      w_drop_next = w_out_next;
    end else if (w_drop) begin
      w_drop_next = r_drop_cnt - OUT_W'(1);
    end
  end

  always_comb begin
    w_cnt_next = r_fifo_cnt;
    if (w_flush) begin
      w_cnt_next = '0;
    end else if (w_push && !w_pop) begin
      w_cnt_next = r_fifo_cnt + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_cnt_next = r_fifo_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    w_req_pc_next = r_req_pc;
    if (!halt && redirect) begin
      w_req_pc_next = {redirect_pc[31:2], 2'b00};
    end else if (w_grant) begin
      w_req_pc_next = r_req_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_pc      <= RESET_PC;
      r_fifo_wr     <= '0;
      r_fifo_rd     <= '0;
      r_fifo_cnt    <= '0;
      r_pcq_wr      <= '0;
      r_pcq_rd      <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_halted      <= 1'b0;
    end else begin
      r_req_pc      <= w_req_pc_next;
      r_fifo_cnt    <= w_cnt_next;
      r_outstanding <= w_out_next;
      r_drop_cnt    <= w_drop_next;
      if (halt) begin
        r_halted <= 1'b1;
      end
      if (w_flush) begin
        r_fifo_wr <= '0;
        r_fifo_rd <= '0;
        r_pcq_wr  <= '0;
        r_pcq_rd  <= '0;
      end else begin
        if (w_push) begin
          r_fifo_wr <= r_fifo_wr + PTR_W'(1);
        end
        if (w_pop) begin
          r_fifo_rd <= r_fifo_rd + PTR_W'(1);
        end
        if (w_grant) begin
          r_pcq_wr <= r_pcq_wr + PTR_W'(1);
        end
        if (w_keep) begin
          r_pcq_rd <= r_pcq_rd + PTR_W'(1);
        end
      end
    end
  end

  // Storage needs no reset: the head is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_fifo_wr]   <= w_pcq_head;
      r_fifo_word[r_fifo_wr] <= imem_rdata;
    end
    if (w_grant) begin
      r_pcq[r_pcq_wr] <= r_req_pc;
    end
  end

  a_no_fifo_overflow : assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_fifo_cnt == CNT_W'(BUF_DEPTH))));

  a_no_orphan_response : assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (r_outstanding == '0)));

  a_no_counter_wrap : assert property (@(posedge clk) disable iff (rst)
    !(w_grant && (&r_outstanding)));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order memory model plus a
// program-order model of which PCs the decoder must see, in what order.
module tb_fetch_unit;

  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PATTERN   = 32'hFFFF_0000;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mem_req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;

  fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  mem_req_t    memq[$];
  int          cyc;
  int          gnt_pct, ready_pct, rv_pct, lat_min, lat_max;
  logic [31:0] exp_pc, exp_req, last_pop_pc, first_pop_pc, pair_tgt;
  bit          exp_halted, pair_armed, pair_hit;
  int          n_pops, n_grants, first_pop_cyc, n_pops_all;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a falling edge; returns at a falling edge with rst released.
  task automatic do_reset();
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_halted", halted, 0);
    memq.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_pc = RESET_PC; exp_req = RESET_PC; exp_halted = 1'b0;
    cyc = 0; n_pops = 0; n_grants = 0; first_pop_cyc = -1; first_pop_pc = '0;
    pair_armed = 1'b0; pair_hit = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict handshakes, update models.
  task automatic step(input bit rd, input logic [31:0] tgt, input bit hl);
    bit       grant, pop, flush;
    int       due, live;
    mem_req_t tmp;
    imem_gnt   = ($urandom_range(0, 99) < gnt_pct);
    inst_ready = ($urandom_range(0, 99) < ready_pct);
    if (memq.size() > 0 && memq[0].due <= cyc && $urandom_range(0, 99) < rv_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memq[0].addr ^ PATTERN;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom();
    end
    redirect = rd; redirect_pc = tgt; halt = hl;
    #1;
    if (pair_armed && !hl && inst_valid && imem_rvalid) begin
      redirect = 1'b1; redirect_pc = pair_tgt;
      pair_armed = 1'b0; pair_hit = 1'b1;
      #1;
    end
    flush = redirect || halt;
    check("halted", halted, exp_halted);
    if (exp_halted) check("inst_valid_after_halt", inst_valid, 0);
    if (exp_halted || redirect) check("req_blocked", imem_req, 0);
    grant = imem_req && imem_gnt;
    pop   = inst_valid && inst_ready;
    if (imem_rvalid) tmp = memq.pop_front();
    if (grant) begin
      check("req_addr", imem_addr, exp_req);
      exp_req = exp_req + 32'd4;
      due = cyc + $urandom_range(lat_min, lat_max);
      if (memq.size() > 0 && memq[memq.size()-1].due > due) due = memq[memq.size()-1].due;
      memq.push_back('{imem_addr, due, 1'b0});
      live = 0;
      foreach (memq[i]) if (!memq[i].stale) live++;
      check("live_inflight_bound", live <= BUF_DEPTH, 1);
      n_grants++;
    end
    if (pop) begin
      check("inst_pc", inst_pc, exp_pc);
      check("inst_word", inst, exp_pc ^ PATTERN);
      $display("cycle %0d: decode pc=%h word=%h", cyc, inst_pc, inst);
      if (n_pops == 0) begin
        first_pop_cyc = cyc;
        first_pop_pc  = inst_pc;
      end
      n_pops++; n_pops_all++;
      last_pop_pc = inst_pc;
      exp_pc = exp_pc + 32'd4;
    end
    if (halt) begin
      exp_halted = 1'b1;
    end else if (redirect && !exp_halted) begin
      exp_pc  = {redirect_pc[31:2], 2'b00};
      exp_req = exp_pc;
    end
    if (flush) foreach (memq[i]) memq[i].stale = 1'b1;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_mode(input int g, input int r, input int v, input int lmin, input int lmax);
    gnt_pct = g; ready_pct = r; rv_pct = v; lat_min = lmin; lat_max = lmax;
  endtask

  int          rnd, prev_pops;
  logic [31:0] tgt;

  initial begin
    rst = 1'b1;
    n_pops_all = 0;
    cyc = 0;
    set_mode(100, 100, 100, 1, 1);
    @(negedge clk);

    // Zero-wait memory, decoder always ready.
    do_reset();
    for (int i = 0; i < 20; i++) step(0, '0, 0);
    check("first_inst_cycle", first_pop_cyc, 2);
    check("zero_wait_progress", n_pops >= 10, 1);

    // Decoder stalled: buffer fills to BUF_DEPTH and requests stop.
    do_reset();
    set_mode(100, 0, 100, 1, 1);
    for (int i = 0; i < 10; i++) step(0, '0, 0);
    check("stall_grants", n_grants, BUF_DEPTH);
    check("stall_req_low", imem_req, 0);
    check("stall_head_valid", inst_valid, 1);
    check("stall_head_pc", inst_pc, RESET_PC);
    ready_pct = 100;
    for (int i = 0; i < 10; i++) step(0, '0, 0);
    check("stall_release_progress", n_pops >= 3, 1);

    // Latency 3 with two in flight, redirect to an unaligned target.
    do_reset();
    set_mode(100, 100, 100, 3, 3);
    step(0, '0, 0);
    step(0, '0, 0);
    step(1, 32'h0000_0103, 0);
    redirect = 1'b0;
    #1;
    check("redir_req", imem_req, 1);
    check("redir_addr", imem_addr, 32'h0000_0100);
    for (int i = 0; i < 15; i++) step(0, '0, 0);
    check("redir_first_pc", first_pop_pc, 32'h0000_0100);
    check("redir_progress", n_pops >= 2, 1);

    // Redirect coinciding with a decoder handshake and a response.
    do_reset();
    set_mode(100, 100, 100, 1, 1);
    pair_tgt = 32'h0000_0200;
    pair_armed = 1'b1;
    for (int i = 0; i < 12; i++) step(0, '0, 0);
    check("pair_redirect_seen", pair_hit, 1);
    check("pair_resume", (last_pop_pc >= 32'h200) && (last_pop_pc < 32'h240), 1);

    // Halt with one request outstanding, then restart from reset.
    do_reset();
    set_mode(100, 100, 100, 3, 3);
    step(0, '0, 0);
    step(0, '0, 1);
    halt = 1'b0;
    #1;
    check("halt_flag", halted, 1);
    check("halt_valid", inst_valid, 0);
    check("halt_req", imem_req, 0);
    for (int i = 0; i < 20; i++) step(0, '0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, '0, 0);
    check("restart_granted", n_grants >= 1, 1);

    // PC wrap from the top of the address space.
    do_reset();
    set_mode(100, 100, 100, 1, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 0);
    step(1, 32'hFFFF_FFFC, 0);
    for (int i = 0; i < 12; i++) step(0, '0, 0);
    check("wrap_low_pc", last_pop_pc < 32'h40, 1);

    // Randomized traffic, redirects (some near the wrap point) and halts.
    prev_pops = n_pops_all;
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      set_mode($urandom_range(40, 100), $urandom_range(30, 100), $urandom_range(50, 100),
               1, $urandom_range(1, 5));
      for (int i = 0; i < 400; i++) begin
        rnd = $urandom_range(0, 999);
        tgt = (rnd % 2 == 1) ? $urandom() : (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
        if (exp_halted && rnd < 30) do_reset();
        else step(rnd < 30, tgt, rnd >= 996);
      end
    end
    check("random_progress", n_pops_all > prev_pops + 100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
